// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared word width, fetch state encoding and reset PC default
package fetch_unit_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous instruction FIFO carrying word and PC, with flush
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WORD-1:0]        push_data,
  input  logic [WORD-1:0]        push_pc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WORD-1:0]        head_data,
  output logic [WORD-1:0]        head_pc,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD-1:0] data_mem [DEPTH];
  logic [WORD-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch front end: PC sequencing, request throttling, redirect and fault handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [WORD-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [WORD-1:0] inst,
  output logic [WORD-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            fetch_fault
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int BW = CW + 1;

  fetch_state_t    state, state_nx;
  logic [WORD-1:0] pc, pc_nx, resp_pc, resp_pc_nx;
  logic [CW-1:0]   outstanding, outstanding_nx, discard, discard_nx, occupancy;
  logic            q_full, q_empty, rsp, grant, push, pop;
  logic [BW-1:0]   in_use;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (imem_rdata),
    .push_pc   (resp_pc),
    .pop       (pop),
    .flush     (redirect),
    .head_data (inst),
    .head_pc   (inst_pc),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occupancy)
  );

  assign rsp         = imem_rvalid && (outstanding != '0);
  assign grant       = imem_req && imem_gnt;
  assign inst_valid  = (state == RUN) && !q_empty;
  assign pop         = inst_valid && inst_ready && !redirect;
  assign push        = rsp && (discard == '0) && (state == RUN) && !redirect && !q_full;
  assign fetch_fault = (state == FAULT);
  assign imem_addr   = pc;

  // A slot freed by this cycle's pop is reusable at once, sustaining one fetch per cycle.
  assign in_use   = BW'(occupancy) - BW'(pop) + BW'(outstanding);
  assign imem_req = (state == RUN) && !redirect && (in_use < BW'(QDEPTH));

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    resp_pc_nx     = resp_pc;
    outstanding_nx = outstanding - CW'(rsp);
    discard_nx     = discard;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      state_nx   = word_aligned(redirect_pc[1:0]) ? RUN : FAULT;
      pc_nx      = redirect_pc;
      resp_pc_nx = redirect_pc;
      discard_nx = outstanding_nx;
    end else begin
      if (state == BOOT) begin
        state_nx = RUN;
      end
      if (grant) begin
        pc_nx          = pc + 32'd4;
        outstanding_nx = outstanding_nx + CW'(1);
      end
      if (rsp && (discard != '0)) begin
        discard_nx = discard - CW'(1);
      end
      if (push) begin
        resp_pc_nx = resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      resp_pc     <= resp_pc_nx;
      outstanding <= outstanding_nx;
      discard     <= discard_nx;
    end
  end

endmodule
